nibble_serializer: RTL

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

---
 rtl/nibble_serializer_pkg.sv | 13 +
 rtl/nibble_serializer_if.sv | 25 ++
 rtl/nibble_serializer_mux.sv | 23 ++
 rtl/nibble_serializer.sv | 99 +++++++++
 4 files changed

// File: rtl/nibble_serializer_pkg.sv
// rtl/nibble_serializer_pkg.sv - shared widths and FSM state encodings for the nibble serializer
package nibble_serializer_pkg;

  localparam int NIB_W         = 4;
  localparam int WORD_W        = 16;
  localparam int NIBS_PER_WORD = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/nibble_serializer_if.sv
// rtl/nibble_serializer_if.sv - word-in / nibble-out handshake bundle
interface nibble_serializer_if;
  import nibble_serializer_pkg::*;

  logic              word_valid;
  logic [WORD_W-1:0] word_in;
  logic              word_ready;
  logic              nib_valid;
  logic [NIB_W-1:0]  nib_out;
  logic [1:0]        nib_idx;
  logic              nib_last;
  logic              nib_ready;

  // master supplies words and consumes nibbles; slave is the serializer
  modport master (
    output word_valid, word_in, nib_ready,
    input  word_ready, nib_valid, nib_out, nib_idx, nib_last
  );

  modport slave (
    input  word_valid, word_in, nib_ready,
    output word_ready, nib_valid, nib_out, nib_idx, nib_last
  );

endinterface

// File: rtl/nibble_serializer_mux.sv
// rtl/nibble_serializer_mux.sv - combinational 4:1 nibble selector
module nibble_mux_4
  import nibble_serializer_pkg::*;
(
  input  logic [1:0]       sel,
  input  logic [NIB_W-1:0] in0,
  input  logic [NIB_W-1:0] in1,
  input  logic [NIB_W-1:0] in2,
  input  logic [NIB_W-1:0] in3,
  output logic [NIB_W-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - splits 16-bit words into four 4-bit nibbles with
// ready/valid handshakes on both sides and zero-bubble back-to-back loading
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  nibble_serializer_if.slave bus
);

  localparam logic [1:0] LAST_CNT = 2'(NIBS_PER_WORD - 1);

  state_t            state, state_next;
  logic [1:0]        count, count_next;
  logic [WORD_W-1:0] hold;
  logic              load;
  logic              at_last;
  logic              word_ready;
  logic              nib_valid;
  logic [1:0]        sel;
  logic [NIB_W-1:0]  mux_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= 2'd0;
      hold  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (load) begin
        hold <= bus.word_in;
      end
    end
  end

  assign at_last = (state == ST_SEND) && (count == LAST_CNT);

  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    word_ready = 1'b0;
    nib_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        word_ready = 1'b1;
        if (bus.word_valid) begin
          state_next = ST_SEND;
          count_next = 2'd0;
          load       = 1'b1;
        end
      end
      ST_SEND: begin
        nib_valid = 1'b1;
        // a new word is only accepted as the last nibble leaves, so no bubble
        if (at_last) begin
          word_ready = bus.nib_ready;
        end
        if (bus.nib_ready) begin
          if (!at_last) begin
            count_next = count + 2'd1;
          end else if (bus.word_valid) begin
            load       = 1'b1;
            count_next = 2'd0;
          end else begin
            state_next = ST_IDLE;
            count_next = 2'd0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 2'd0;
      end
    endcase
  end

  assign sel = MSB_FIRST ? (LAST_CNT - count) : count;

  nibble_mux_4 u_mux (
    .sel (sel),
    .in0 (hold[3:0]),
    .in1 (hold[7:4]),
    .in2 (hold[11:8]),
    .in3 (hold[15:12]),
    .out (mux_out)
  );

  // outputs are forced to zero outside SEND so reset/idle values are clean
  assign bus.word_ready = word_ready;
  assign bus.nib_valid  = nib_valid;
  assign bus.nib_out    = nib_valid ? mux_out : '0;
  assign bus.nib_idx    = nib_valid ? sel : 2'd0;
  assign bus.nib_last   = at_last;

endmodule
